// File: rtl/pep_mmacc_boram_rd_arb.sv
// ============================================================================
// Module      : pep_mmacc_boram_rd_arb
// Description : Round-robin read arbiter for the MMACC body RAM with in-order
//               response routing through a tag FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pep_common_param_pkg;
    localparam int PID_W = 7;
endpackage

package param_tfhe_pkg;
    localparam int LWE_COEF_W = 32;
endpackage

module pep_mmacc_boram_rd_arb
    import pep_common_param_pkg::*;
    import param_tfhe_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int TAG_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           s_rst_n,

    input  logic [NREQ-1:0][PID_W-1:0]     req_pid,
    input  logic [NREQ-1:0]                req_parity,
    input  logic [NREQ-1:0]                req_vld,
    output logic [NREQ-1:0]                req_rdy,

    output logic [PID_W-1:0]               boram_rd_pid,
    output logic                           boram_rd_parity,
    output logic                           boram_rd_vld,
    input  logic                           boram_rd_rdy,

    input  logic [LWE_COEF_W-1:0]          boram_sxt_data,
    input  logic                           boram_sxt_data_vld,
    output logic                           boram_sxt_data_rdy,

    output logic [LWE_COEF_W-1:0]          rsp_data,
    output logic [NREQ-1:0]                rsp_vld,
    input  logic [NREQ-1:0]                rsp_rdy,

    output logic [$clog2(TAG_DEPTH):0]     outstd_cnt,
    output logic                           err_orphan
);

    localparam int IDX_W  = $clog2(NREQ);
    localparam int TAG_AW = $clog2(TAG_DEPTH);
    localparam int CNT_W  = TAG_AW + 1;

    logic [IDX_W-1:0]                  rr_ptr_q,   rr_ptr_d;
    logic                              lock_vld_q, lock_vld_d;
    logic [IDX_W-1:0]                  lock_idx_q, lock_idx_d;
    logic [TAG_DEPTH-1:0][IDX_W-1:0]   tag_mem_q,  tag_mem_d;
    logic [TAG_AW-1:0]                 wr_ptr_q,   wr_ptr_d;
    logic [TAG_AW-1:0]                 rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]                  cnt_q,      cnt_d;
    logic                              err_q,      err_d;

    logic                              grant_found;
    logic [IDX_W-1:0]                  grant_idx;
    logic                              issue;
    logic                              pop;
    logic                              tag_empty;
    logic [IDX_W-1:0]                  head_idx;
    int                                cand;

    // A pending (locked) request keeps its grant; otherwise search from rr_ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        if (lock_vld_q) begin
            grant_found = 1'b1;
            grant_idx   = lock_idx_q;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                cand = int'(rr_ptr_q) + k;
                if (cand >= NREQ) begin
                    cand = cand - NREQ;
                end
                if (!grant_found && req_vld[cand[IDX_W-1:0]]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand[IDX_W-1:0];
                end
            end
        end
    end

    assign tag_empty       = (cnt_q == '0);
    assign head_idx        = tag_mem_q[rd_ptr_q];

    assign boram_rd_vld    = grant_found && (cnt_q < CNT_W'(TAG_DEPTH));
    assign boram_rd_pid    = req_pid[grant_idx];
    assign boram_rd_parity = req_parity[grant_idx];
    assign issue           = boram_rd_vld && boram_rd_rdy;

    assign boram_sxt_data_rdy = !tag_empty && rsp_rdy[head_idx];
    assign pop                = boram_sxt_data_vld && boram_sxt_data_rdy;
    assign rsp_data           = boram_sxt_data;

    always_comb begin
        req_rdy = '0;
        rsp_vld = '0;
        if (issue) begin
            req_rdy[grant_idx] = 1'b1;
        end
        if (!tag_empty) begin
            rsp_vld[head_idx] = boram_sxt_data_vld;
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_vld_d = lock_vld_q;
        lock_idx_d = lock_idx_q;
        tag_mem_d  = tag_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        err_d      = err_q || (boram_sxt_data_vld && tag_empty);

        if (issue) begin
            rr_ptr_d            = (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            lock_vld_d          = 1'b0;
            tag_mem_d[wr_ptr_q] = grant_idx;
            wr_ptr_d            = wr_ptr_q + 1'b1;
        end else if (boram_rd_vld) begin
            lock_vld_d = 1'b1;
            lock_idx_d = grant_idx;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({issue, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            rr_ptr_q   <= '0;
            lock_vld_q <= 1'b0;
            lock_idx_q <= '0;
            tag_mem_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_vld_q <= lock_vld_d;
            lock_idx_q <= lock_idx_d;
            tag_mem_q  <= tag_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign outstd_cnt = cnt_q;
    assign err_orphan = err_q;

`ifndef SYNTHESIS
    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_req_stable
            a_req_stable : assert property (@(posedge clk) disable iff (!s_rst_n)
                (req_vld[i] && !req_rdy[i]) |=> ($stable(req_pid[i]) && $stable(req_parity[i])));
        end
    endgenerate

    a_no_pop_empty : assert property (@(posedge clk) disable iff (!s_rst_n)
        !(pop && tag_empty));
    a_no_push_full : assert property (@(posedge clk) disable iff (!s_rst_n)
        !(issue && (cnt_q == CNT_W'(TAG_DEPTH))));
`endif

endmodule

`default_nettype wire

// File: tb/tb_pep_mmacc_boram_rd_arb.sv
// ============================================================================
// Module      : tb_pep_mmacc_boram_rd_arb
// Description : Scoreboard bench for the body-RAM read arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pep_mmacc_boram_rd_arb;

    localparam int NREQ      = 2;
    localparam int TAG_DEPTH = 4;
    localparam int PID_W     = pep_common_param_pkg::PID_W;
    localparam int LW        = param_tfhe_pkg::LWE_COEF_W;
    localparam int CNT_W     = $clog2(TAG_DEPTH) + 1;

    logic                       clk;
    logic                       s_rst_n;
    logic [NREQ-1:0][PID_W-1:0] req_pid;
    logic [NREQ-1:0]            req_parity;
    logic [NREQ-1:0]            req_vld;
    logic [NREQ-1:0]            req_rdy;
    logic [PID_W-1:0]           boram_rd_pid;
    logic                       boram_rd_parity;
    logic                       boram_rd_vld;
    logic                       boram_rd_rdy;
    logic [LW-1:0]              boram_sxt_data;
    logic                       boram_sxt_data_vld;
    logic                       boram_sxt_data_rdy;
    logic [LW-1:0]              rsp_data;
    logic [NREQ-1:0]            rsp_vld;
    logic [NREQ-1:0]            rsp_rdy;
    logic [CNT_W-1:0]           outstd_cnt;
    logic                       err_orphan;

    pep_mmacc_boram_rd_arb #(
        .NREQ      (NREQ),
        .TAG_DEPTH (TAG_DEPTH)
    ) u_dut (
        .clk                (clk),
        .s_rst_n            (s_rst_n),
        .req_pid            (req_pid),
        .req_parity         (req_parity),
        .req_vld            (req_vld),
        .req_rdy            (req_rdy),
        .boram_rd_pid       (boram_rd_pid),
        .boram_rd_parity    (boram_rd_parity),
        .boram_rd_vld       (boram_rd_vld),
        .boram_rd_rdy       (boram_rd_rdy),
        .boram_sxt_data     (boram_sxt_data),
        .boram_sxt_data_vld (boram_sxt_data_vld),
        .boram_sxt_data_rdy (boram_sxt_data_rdy),
        .rsp_data           (rsp_data),
        .rsp_vld            (rsp_vld),
        .rsp_rdy            (rsp_rdy),
        .outstd_cnt         (outstd_cnt),
        .err_orphan         (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_checks;
    int            n_errors;
    int            sb_q[$];
    logic [LW-1:0] next_data;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Expect requester idx to be accepted this cycle; record it for routing.
    task automatic expect_grant(input int idx, input logic [PID_W-1:0] pid,
                                input logic par, input string tag);
        check_eq({tag, "_req_rdy"}, 64'(req_rdy), 64'(1 << idx));
        check_eq({tag, "_pid"}, 64'(boram_rd_pid), 64'(pid));
        check_eq({tag, "_parity"}, 64'(boram_rd_parity), 64'(par));
        sb_q.push_back(idx);
    endtask

    // Return data d is on the bus with all rsp_rdy high.
    task automatic expect_rsp(input logic [LW-1:0] d, input string tag);
        int idx;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_sb: got empty scoreboard expected pending entry", tag);
        end else begin
            idx = sb_q.pop_front();
            check_eq({tag, "_rsp_vld"}, 64'(rsp_vld), 64'(1 << idx));
            check_eq({tag, "_rsp_data"}, 64'(rsp_data), 64'(d));
            check_eq({tag, "_data_rdy"}, 64'(boram_sxt_data_rdy), 64'(1));
        end
    endtask

    task automatic issue_one(input int idx, input logic [PID_W-1:0] pid);
        req_vld          = '0;
        req_vld[idx]     = 1'b1;
        req_pid[idx]     = pid;
        req_parity[idx]  = pid[0];
        boram_rd_rdy     = 1'b1;
        #1;
        expect_grant(idx, pid, pid[0], "issue");
        tick();
        req_vld      = '0;
        boram_rd_rdy = 1'b0;
    endtask

    task automatic do_return(input logic [LW-1:0] d);
        boram_sxt_data_vld = 1'b1;
        boram_sxt_data     = d;
        rsp_rdy            = '1;
        #1;
        expect_rsp(d, "ret");
        tick();
        boram_sxt_data_vld = 1'b0;
        rsp_rdy            = '0;
    endtask

    task automatic drain();
        while (sb_q.size() > 0) begin
            do_return(next_data);
            next_data = next_data + 1'b1;
        end
        check_eq("drain_cnt", 64'(outstd_cnt), 64'(0));
    endtask

    initial begin
        n_checks           = 0;
        n_errors           = 0;
        next_data          = LW'(32'h100);
        s_rst_n            = 1'b0;
        req_pid            = '0;
        req_parity         = '0;
        req_vld            = '0;
        boram_rd_rdy       = 1'b0;
        boram_sxt_data     = '0;
        boram_sxt_data_vld = 1'b0;
        rsp_rdy            = '0;

        // Reset state
        repeat (3) tick();
        #1;
        check_eq("rst_cnt", 64'(outstd_cnt), 64'(0));
        check_eq("rst_err", 64'(err_orphan), 64'(0));
        tick();
        s_rst_n = 1'b1;
        #1;
        check_eq("rst_rd_vld", 64'(boram_rd_vld), 64'(0));
        check_eq("rst_req_rdy", 64'(req_rdy), 64'(0));
        check_eq("rst_rsp_vld", 64'(rsp_vld), 64'(0));
        check_eq("rst_data_rdy", 64'(boram_sxt_data_rdy), 64'(0));
        tick();

        // Both requesting continuously: grants alternate 0,1,0,1
        req_pid[0]   = 7'd0;
        req_pid[1]   = 7'd1;
        req_parity   = 2'b00;
        req_vld      = 2'b11;
        boram_rd_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            expect_grant(k % 2, req_pid[k % 2], req_parity[k % 2], "rr");
            tick();
            req_pid[k % 2] = req_pid[k % 2] + 7'd2;
        end
        #1;
        check_eq("rr_full_cnt", 64'(outstd_cnt), 64'(4));
        check_eq("rr_full_vld", 64'(boram_rd_vld), 64'(0));
        check_eq("rr_full_rdy", 64'(req_rdy), 64'(0));
        tick();
        req_vld      = '0;
        boram_rd_rdy = 1'b0;
        drain();

        // Lock: move rr_ptr to 1, then stall req0 while req1 joins
        issue_one(0, 7'd1);
        req_vld    = 2'b01;
        req_pid[0] = 7'd5;
        req_parity = 2'b01;
        #1;
        check_eq("lock_vld", 64'(boram_rd_vld), 64'(1));
        for (int k = 0; k < 3; k++) begin
            check_eq("lock_pid", 64'(boram_rd_pid), 64'(5));
            check_eq("lock_rdy", 64'(req_rdy), 64'(0));
            tick();
            req_vld    = 2'b11;
            req_pid[1] = 7'd9;
            #1;
        end
        boram_rd_rdy = 1'b1;
        #1;
        expect_grant(0, 7'd5, 1'b1, "lock_rel");
        tick();
        req_vld = 2'b10;
        #1;
        expect_grant(1, 7'd9, 1'b0, "lock_next");
        tick();
        req_vld      = '0;
        boram_rd_rdy = 1'b0;
        drain();

        // Fill to TAG_DEPTH, then one return frees a slot for the next cycle
        req_vld      = 2'b10;
        boram_rd_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_pid[1]    = PID_W'(20 + k);
            req_parity[1] = k[0];
            #1;
            expect_grant(1, PID_W'(20 + k), k[0], "fill");
            tick();
        end
        #1;
        check_eq("fill_cnt", 64'(outstd_cnt), 64'(4));
        check_eq("fill_vld", 64'(boram_rd_vld), 64'(0));
        check_eq("fill_rdy", 64'(req_rdy), 64'(0));
        boram_sxt_data_vld = 1'b1;
        boram_sxt_data     = LW'(32'h55);
        rsp_rdy            = '1;
        #1;
        check_eq("nobypass_vld", 64'(boram_rd_vld), 64'(0));
        expect_rsp(LW'(32'h55), "fill_ret");
        tick();
        boram_sxt_data_vld = 1'b0;
        rsp_rdy            = '0;
        #1;
        check_eq("refill_cnt3", 64'(outstd_cnt), 64'(3));
        expect_grant(1, 7'd23, 1'b1, "refill");
        tick();
        #1;
        check_eq("refill_cnt", 64'(outstd_cnt), 64'(4));
        req_vld      = '0;
        boram_rd_rdy = 1'b0;
        drain();

        // Ordered routing 1,0,1 with a stalled head not blocking issue
        issue_one(1, 7'd3);
        issue_one(0, 7'd7);
        issue_one(1, 7'd9);
        boram_sxt_data_vld = 1'b1;
        boram_sxt_data     = LW'(32'hA);
        rsp_rdy            = '0;
        req_vld            = 2'b01;
        req_pid[0]         = 7'd11;
        req_parity[0]      = 1'b1;
        boram_rd_rdy       = 1'b1;
        #1;
        check_eq("stall_rsp_vld", 64'(rsp_vld), 64'(1 << sb_q[0]));
        check_eq("stall_data_rdy", 64'(boram_sxt_data_rdy), 64'(0));
        expect_grant(0, 7'd11, 1'b1, "stall_issue");
        tick();
        req_vld      = '0;
        boram_rd_rdy = 1'b0;
        do_return(LW'(32'hA));
        do_return(LW'(32'hB));
        do_return(LW'(32'hC));
        drain();

        // Simultaneous issue and return keeps the count
        issue_one(0, 7'd40);
        req_vld            = 2'b10;
        req_pid[1]         = 7'd41;
        req_parity[1]      = 1'b1;
        boram_rd_rdy       = 1'b1;
        boram_sxt_data_vld = 1'b1;
        boram_sxt_data     = LW'(32'h77);
        rsp_rdy            = '1;
        #1;
        expect_rsp(LW'(32'h77), "simul");
        expect_grant(1, 7'd41, 1'b1, "simul");
        tick();
        req_vld            = '0;
        boram_rd_rdy       = 1'b0;
        boram_sxt_data_vld = 1'b0;
        rsp_rdy            = '0;
        #1;
        check_eq("simul_cnt", 64'(outstd_cnt), 64'(1));
        drain();

        // Orphan data
        boram_sxt_data_vld = 1'b1;
        boram_sxt_data     = LW'(32'hDEAD);
        rsp_rdy            = '1;
        #1;
        check_eq("orphan_data_rdy", 64'(boram_sxt_data_rdy), 64'(0));
        check_eq("orphan_rsp_vld", 64'(rsp_vld), 64'(0));
        check_eq("orphan_err_pre", 64'(err_orphan), 64'(0));
        tick();
        boram_sxt_data_vld = 1'b0;
        rsp_rdy            = '0;
        #1;
        check_eq("orphan_err", 64'(err_orphan), 64'(1));
        repeat (3) tick();
        #1;
        check_eq("orphan_sticky", 64'(err_orphan), 64'(1));

        // Reset with three outstanding reads and rr_ptr at 1
        issue_one(1, 7'd50);
        issue_one(1, 7'd51);
        issue_one(0, 7'd52);
        #1;
        check_eq("pre_rst_cnt", 64'(outstd_cnt), 64'(3));
        s_rst_n = 1'b0;
        tick();
        tick();
        s_rst_n = 1'b1;
        sb_q.delete();
        #1;
        check_eq("post_rst_cnt", 64'(outstd_cnt), 64'(0));
        check_eq("post_rst_err", 64'(err_orphan), 64'(0));
        check_eq("post_rst_rsp_vld", 64'(rsp_vld), 64'(0));
        req_vld      = 2'b11;
        req_pid[0]   = 7'd60;
        req_pid[1]   = 7'd61;
        req_parity   = 2'b00;
        boram_rd_rdy = 1'b1;
        #1;
        expect_grant(0, 7'd60, 1'b0, "post_rst_rr");
        tick();
        req_vld      = '0;
        boram_rd_rdy = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pep_mmacc_boram_rd_arb.md
PEP_MMACC_BORAM_RD_ARB -- requirements
Module: pep_mmacc_boram_rd_arb

Interface
REQ-001 Parameter NREQ, default 2, number of requesters sharing the body-RAM read port (2..8).
REQ-002 Parameter TAG_DEPTH, default 4, maximum outstanding reads; power of 2, 2..16.
REQ-003 PID_W and LWE_COEF_W SHALL be taken from pep_common_param_pkg and param_tfhe_pkg.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 s_rst_n  in  1  reset, synchronous, active-low.
REQ-006 req_pid  in  NREQ x PID_W  per-requester PID to read.
REQ-007 req_parity  in  NREQ  per-requester parity.
REQ-008 req_vld / req_rdy  in / out  NREQ each  per-requester request handshake.
REQ-009 boram_rd_pid, boram_rd_parity, boram_rd_vld  out  PID_W, 1, 1  read request to body RAM.
REQ-010 boram_rd_rdy  in  1  body RAM accepts request.
REQ-011 boram_sxt_data, boram_sxt_data_vld  in  LWE_COEF_W, 1  in-order read data from body RAM.
REQ-012 boram_sxt_data_rdy  out  1  data accept to body RAM.
REQ-013 rsp_data  out  LWE_COEF_W  broadcast copy of boram_sxt_data.
REQ-014 rsp_vld / rsp_rdy  out / in  NREQ each  per-requester response handshake.
REQ-015 outstd_cnt  out  $clog2(TAG_DEPTH)+1  registered count of issued, unreturned reads.
REQ-016 err_orphan  out  1  sticky flag: data returned with no outstanding read.

Function
REQ-017 Arbitration SHALL be round-robin: among req_vld bits, grant the lowest index >= rr_ptr, wrapping to 0.
REQ-018 rr_ptr SHALL update to (granted index + 1) mod NREQ on each accepted issue (boram_rd_vld & boram_rd_rdy); otherwise it holds.
REQ-019 Once boram_rd_vld is asserted for index g without boram_rd_rdy, a lock register SHALL hold g and pid/parity stable until handshake, regardless of other req_vld.
REQ-020 boram_rd_vld SHALL be (any eligible req_vld or lock active) AND outstd_cnt < TAG_DEPTH; no same-cycle bypass of a pop into a free slot.
REQ-021 req_rdy[i] SHALL equal boram_rd_rdy AND boram_rd_vld AND (grant == i); at most one req_rdy high per cycle.
REQ-022 boram_rd_pid/parity SHALL be the granted requester's req_pid/req_parity, combinational from the grant mux.
REQ-023 On each issue, the granted index SHALL be pushed into a TAG_DEPTH-entry tag FIFO (registered wr/rd pointers, wrap at TAG_DEPTH).
REQ-024 Head tag h drives routing: rsp_vld[h] = boram_sxt_data_vld AND tag FIFO non-empty; other rsp_vld bits 0.
REQ-025 boram_sxt_data_rdy SHALL be rsp_rdy[h] AND tag FIFO non-empty; response handshake pops the tag FIFO.
REQ-026 Return and response latency through this block SHALL be 0 cycles (combinational routing); issue latency 0 cycles.
REQ-027 Simultaneous issue and return: push and pop both occur, outstd_cnt unchanged.
REQ-028 outstd_cnt SHALL increment on issue only, decrement on return only, never exceed TAG_DEPTH or go below 0.
REQ-029 boram_sxt_data_vld with tag FIFO empty: boram_sxt_data_rdy stays 0, err_orphan set to 1 next cycle, held until reset.
REQ-030 A response stalled by rsp_rdy[h]=0 SHALL not block issue while outstd_cnt < TAG_DEPTH.
REQ-031 Simulation-only assertions SHALL flag: req_pid/parity change while req_vld high and not accepted; pop on empty; push on full.

Reset
REQ-032 While s_rst_n=0: rr_ptr=0, lock cleared, tag FIFO empty, outstd_cnt=0, err_orphan=0.
REQ-033 Out of reset: boram_rd_vld=0 unless req_vld asserted, req_rdy=0, rsp_vld=0, boram_sxt_data_rdy=0.
REQ-034 Reset mid-operation SHALL discard all outstanding tags; body RAM reset together by the same s_rst_n.

Verification
REQ-035 NREQ=2, both req_vld=1 continuously, boram_rd_rdy=1 -> grants alternate 0,1,0,1; rr_ptr toggles each cycle.
REQ-036 req0 pid=5 valid, boram_rd_rdy=0 for 3 cycles, req1 asserts on cycle 1 -> boram_rd_pid stays 5, req_rdy[1]=0 until req0 accepted.
REQ-037 TAG_DEPTH=4, 4 issues, no returns -> outstd_cnt=4, boram_rd_vld=0; one return -> next cycle issue resumes, outstd_cnt back to 4.
REQ-038 Issues from req 1,0,1 with pids 3,7,9, data returned 0xA,0xB,0xC -> rsp_vld pulses on 1,0,1 in that order with matching data.
REQ-039 boram_sxt_data_vld=1 with outstd_cnt=0 -> boram_sxt_data_rdy=0, err_orphan=1 next cycle and stays until s_rst_n=0.
REQ-040 Reset asserted with outstd_cnt=3 -> after release outstd_cnt=0, rr_ptr=0, all rsp_vld=0.
